// File: rtl/sram_bus_ctrl.sv
// -----------------------------------------------------------------------------
// sram_bus_ctrl
//
// Single-port controller that turns a simple host request (req/we/addr/wdata)
// into an asynchronous-SRAM strobe sequence: SETUP -> ACCESS (WAIT_CYC cycles)
// -> HOLD -> IDLE. Every output comes straight from a flop, so the next-state
// logic computes the next output values from the next state and the
// transaction attributes.
//
// Parameters
//   ADDR_W   : external SRAM address width
//   DATA_W   : data bus width
//   WAIT_CYC : strobe width in ACCESS, legal range 1..15
//
// Ports
//   clk       : clock, all state changes on the rising edge
//   reset     : synchronous active-high reset
//   req       : host request, accepted when req && ready on a rising edge
//   we        : 1 = write, 0 = read (qualified by req)
//   addr      : host address
//   wdata     : host write data
//   ready     : high only in IDLE
//   done      : one-cycle completion pulse (during HOLD)
//   rdata     : read data, valid from done until the next read completes
//   sram_addr : SRAM address pins, keep their last value in IDLE
//   sram_dout : data to the pad output driver
//   sram_din  : data from the pad input buffer
//   sram_oe   : pad output enable, 1 = drive the data bus
//   ce_n      : active-low chip enable
//   we_n      : active-low write enable
//   oe_n      : active-low output enable
// -----------------------------------------------------------------------------
module sram_bus_ctrl #(
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 8,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dout,
  input  logic [DATA_W-1:0] sram_din,
  output logic              sram_oe,
  output logic              ce_n,
  output logic              we_n,
  output logic              oe_n
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0] sram_dout_q, sram_dout_d;
  logic              sram_oe_q, sram_oe_d;
  logic              ce_n_q, ce_n_d;
  logic              we_n_q, we_n_d;
  logic              oe_n_q, oe_n_d;
  logic              accept;

  // ready_q is only high in IDLE, so a request while busy is simply dropped.
  assign accept = req && ready_q;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    rdata_d     = rdata_q;
    // sram_addr_q / sram_dout_q double as the latched host address and data.
    sram_addr_d = sram_addr_q;
    sram_dout_d = sram_dout_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = SETUP;
          we_d        = we;
          sram_addr_d = addr;
          sram_dout_d = wdata;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = 4'(WAIT_CYC - 1);
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = HOLD;
          // Edge ending the last ACCESS cycle: data has had the full strobe.
          if (!we_q) rdata_d = sram_din;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Registered outputs are derived from the state being entered.
    ready_d   = 1'b0;
    done_d    = 1'b0;
    ce_n_d    = 1'b1;
    we_n_d    = 1'b1;
    oe_n_d    = 1'b1;
    sram_oe_d = 1'b0;
    unique case (state_d)
      IDLE:  ready_d = 1'b1;
      SETUP: begin
        ce_n_d    = 1'b0;
        oe_n_d    = we_d;
        sram_oe_d = we_d;
      end
      ACCESS: begin
        ce_n_d    = 1'b0;
        we_n_d    = !we_d;
        oe_n_d    = we_d;
        sram_oe_d = we_d;
      end
      HOLD: begin
        // Strobes released, but the pad keeps driving write data for hold time.
        ce_n_d    = 1'b0;
        sram_oe_d = we_d;
        done_d    = 1'b1;
      end
      default: ready_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      rdata_q     <= '0;
      sram_addr_q <= '0;
      sram_dout_q <= '0;
      sram_oe_q   <= 1'b0;
      ce_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      sram_addr_q <= sram_addr_d;
      sram_dout_q <= sram_dout_d;
      sram_oe_q   <= sram_oe_d;
      ce_n_q      <= ce_n_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
    end
  end

  assign ready     = ready_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign sram_addr = sram_addr_q;
  assign sram_dout = sram_dout_q;
  assign sram_oe   = sram_oe_q;
  assign ce_n      = ce_n_q;
  assign we_n      = we_n_q;
  assign oe_n      = oe_n_q;

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_bus_ctrl
//
// Two controllers share the host bus: dut_a with WAIT_CYC=2, dut_b with
// WAIT_CYC=1, each with its own request line and its own behavioural SRAM.
// Expected strobe waveforms come from a per-cycle phase table (SETUP, ACCESS
// window, HOLD, first IDLE); expected read data comes from a host-level
// reference memory holding what was written through each controller.
// -----------------------------------------------------------------------------
module tb_sram_bus_ctrl;

  localparam int AW = 19;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_a, req_b;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;

  logic          ready_a, done_a, sram_oe_a, ce_n_a, we_n_a, oe_n_a;
  logic [DW-1:0] rdata_a, sram_dout_a, sram_din_a;
  logic [AW-1:0] sram_addr_a;
  logic          ready_b, done_b, sram_oe_b, ce_n_b, we_n_b, oe_n_b;
  logic [DW-1:0] rdata_b, sram_dout_b, sram_din_b;
  logic [AW-1:0] sram_addr_b;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sram_bus_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(2)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready_a), .done(done_a), .rdata(rdata_a), .sram_addr(sram_addr_a),
    .sram_dout(sram_dout_a), .sram_din(sram_din_a), .sram_oe(sram_oe_a),
    .ce_n(ce_n_a), .we_n(we_n_a), .oe_n(oe_n_a)
  );

  sram_bus_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(1)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready_b), .done(done_b), .rdata(rdata_b), .sram_addr(sram_addr_b),
    .sram_dout(sram_dout_b), .sram_din(sram_din_b), .sram_oe(sram_oe_b),
    .ce_n(ce_n_b), .we_n(we_n_b), .oe_n(oe_n_b)
  );

  // Behavioural SRAMs, indexed by the low address byte (test addresses are
  // chosen not to alias). A load port lets the bench preload a location.
  logic [DW-1:0] mem_a [256];
  logic [DW-1:0] mem_b [256];
  logic          mem_load = 1'b0;
  logic [7:0]    load_idx = 8'h00;
  logic [DW-1:0] load_val = 8'h00;

  always @(posedge clk) begin
    if (mem_load) begin
      mem_a[load_idx] <= load_val;
      mem_b[load_idx] <= load_val;
    end else begin
      if (!ce_n_a && !we_n_a) mem_a[sram_addr_a[7:0]] <= sram_dout_a;
      if (!ce_n_b && !we_n_b) mem_b[sram_addr_b[7:0]] <= sram_dout_b;
    end
  end

  assign sram_din_a = mem_a[sram_addr_a[7:0]];
  assign sram_din_b = mem_b[sram_addr_b[7:0]];

  // Observation mux so one transaction task serves both controllers.
  typedef struct packed {
    logic          ready, done, ce_n, we_n, oe_n, sram_oe;
    logic [AW-1:0] addr;
    logic [DW-1:0] dout, rdata;
  } obs_t;

  obs_t obs_a, obs_b, obs;
  bit   sel = 1'b0;
  assign obs_a = {ready_a, done_a, ce_n_a, we_n_a, oe_n_a, sram_oe_a, sram_addr_a, sram_dout_a, rdata_a};
  assign obs_b = {ready_b, done_b, ce_n_b, we_n_b, oe_n_b, sram_oe_b, sram_addr_b, sram_dout_b, rdata_b};
  always_comb obs = sel ? obs_b : obs_a;

  // Host-level reference: key = {controller, address}.
  logic [DW-1:0] ref_mem [logic [AW:0]];
  logic [DW-1:0] last_rd [2];
  logic [AW-1:0] wr_q [$];

  int total = 0;
  int bad   = 0;
  int acc1, acc2, n, dn;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input bit s, input logic v);
    if (s) req_b = v;
    else   req_a = v;
  endtask

  // One host transaction with a cycle-by-cycle waveform check.
  // k counts cycles after the accept edge: k=1 SETUP, 2..w+1 ACCESS,
  // w+2 HOLD, w+3 first IDLE cycle. Returns at the negedge of that IDLE cycle.
  task automatic txn(input string nm, input bit s, input int w, input bit wr,
                     input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input bit hold_req, input bit busy_poke, output int acc);
    int            wt, oe_lo, we_lo, soe_hi, done_n, first_done;
    logic [DW-1:0] exp_rd, exp_rdata;
    logic          e_ce_n, e_we_n, e_oe_n, e_soe, e_done, e_ready;
    bit            in_acc;
    sel = s;
    wt = 0;
    while (!obs.ready && wt < 20) begin
      @(negedge clk);
      wt++;
    end
    check({nm, ".ready_wait"}, 32'(obs.ready), 32'd1);
    we = wr; addr = a; wdata = d;
    set_req(s, 1'b1);
    @(negedge clk);
    acc = cyc;
    if (!hold_req) set_req(s, 1'b0);
    exp_rd = wr ? last_rd[s] : ref_mem[{s, a}];
    if (wr) ref_mem[{s, a}] = d;
    oe_lo = 0; we_lo = 0; soe_hi = 0; done_n = 0; first_done = 0;
    for (int k = 1; k <= w + 3; k++) begin
      in_acc = (k >= 2) && (k <= w + 1);
      if (k == w + 3) begin
        e_ce_n = 1'b1; e_we_n = 1'b1; e_oe_n = 1'b1;
        e_soe = 1'b0; e_done = 1'b0; e_ready = 1'b1;
      end else begin
        e_ce_n  = 1'b0;
        e_ready = 1'b0;
        e_done  = (k == w + 2);
        e_we_n  = in_acc ? !wr : 1'b1;
        // Reads open the output buffer from SETUP; the strobe window proper is ACCESS.
        e_oe_n  = (k == 1 || in_acc) ? wr : 1'b1;
        e_soe   = wr;
      end
      exp_rdata = (!wr && k >= w + 2) ? exp_rd : last_rd[s];
      check($sformatf("%s.ce_n@%0d", nm, k),    32'(obs.ce_n),    32'(e_ce_n));
      check($sformatf("%s.we_n@%0d", nm, k),    32'(obs.we_n),    32'(e_we_n));
      check($sformatf("%s.oe_n@%0d", nm, k),    32'(obs.oe_n),    32'(e_oe_n));
      check($sformatf("%s.sram_oe@%0d", nm, k), 32'(obs.sram_oe), 32'(e_soe));
      check($sformatf("%s.done@%0d", nm, k),    32'(obs.done),    32'(e_done));
      check($sformatf("%s.ready@%0d", nm, k),   32'(obs.ready),   32'(e_ready));
      check($sformatf("%s.addr@%0d", nm, k),    32'(obs.addr),    32'(a));
      check($sformatf("%s.rdata@%0d", nm, k),   32'(obs.rdata),   32'(exp_rdata));
      if (k <= w + 2) check($sformatf("%s.dout@%0d", nm, k), 32'(obs.dout), 32'(d));
      check($sformatf("%s.we_oe_excl@%0d", nm, k), 32'(!(!obs.we_n && !obs.oe_n)), 32'd1);
      check($sformatf("%s.bus_fight@%0d", nm, k),  32'(!(obs.sram_oe && !obs.oe_n)), 32'd1);
      if (in_acc && !obs.oe_n) oe_lo++;
      if (!obs.we_n) we_lo++;
      if (obs.sram_oe) soe_hi++;
      if (obs.done) begin
        done_n++;
        if (first_done == 0) first_done = k;
      end
      if (busy_poke && k == 2) begin
        set_req(s, 1'b1);
        addr = a ^ 19'h0F0F0;
      end
      if (busy_poke && k == 3) set_req(s, 1'b0);
      if (k < w + 3) @(negedge clk);
    end
    if (!wr) last_rd[s] = exp_rd;
    check({nm, ".oe_low_cycles"},  32'(oe_lo),      wr ? 32'd0 : 32'(w));
    check({nm, ".we_low_cycles"},  32'(we_lo),      wr ? 32'(w) : 32'd0);
    check({nm, ".sram_oe_cycles"}, 32'(soe_hi),     wr ? 32'(w + 2) : 32'd0);
    check({nm, ".done_pulses"},    32'(done_n),     32'd1);
    check({nm, ".latency"},        32'(first_done), 32'(w + 2));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req_a = 1'b1; req_b = 1'b0;
    we = 1'b0; addr = 19'h01234; wdata = 8'h00;
    last_rd[0] = 8'h00; last_rd[1] = 8'h00;

    // Reset with a request pending: must stay idle with reset values.
    repeat (3) @(negedge clk);
    sel = 1'b0;
    check("rst.ready",   32'(obs.ready),   32'd1);
    check("rst.done",    32'(obs.done),    32'd0);
    check("rst.ce_n",    32'(obs.ce_n),    32'd1);
    check("rst.we_n",    32'(obs.we_n),    32'd1);
    check("rst.oe_n",    32'(obs.oe_n),    32'd1);
    check("rst.sram_oe", 32'(obs.sram_oe), 32'd0);
    check("rst.rdata",   32'(obs.rdata),   32'd0);
    check("rst.addr",    32'(obs.addr),    32'd0);
    check("rst.dout",    32'(obs.dout),    32'd0);
    check("rst_b.ce_n",  32'(ce_n_b),      32'd1);

    // SRAM cell 0x1234 holds 0x5A in both models.
    mem_load = 1'b1; load_idx = 8'h34; load_val = 8'h5A;
    @(negedge clk);
    mem_load = 1'b0;
    ref_mem[{1'b0, 19'h01234}] = 8'h5A;
    ref_mem[{1'b1, 19'h01234}] = 8'h5A;
    check("rst.still_idle", 32'(obs.ce_n), 32'd1);

    // Release reset with req held: accepted on the first edge after.
    reset = 1'b0;
    @(negedge clk);
    check("post_rst.ce_n",  32'(obs.ce_n),  32'd0);
    check("post_rst.ready", 32'(obs.ready), 32'd0);
    check("post_rst.addr",  32'(obs.addr),  32'h01234);
    req_a = 1'b0;
    n = 0; dn = 0;
    while (!obs.ready && n < 10) begin
      @(negedge clk);
      if (obs.done) dn++;
      n++;
    end
    check("post_rst.done_pulses", 32'(dn), 32'd1);
    check("post_rst.rdata", 32'(obs.rdata), 32'h5A);
    last_rd[0] = 8'h5A;

    // Directed read and write on the WAIT_CYC=2 controller.
    txn("rd1234", 1'b0, 2, 1'b0, 19'h01234, 8'h00, 1'b0, 1'b0, acc1);
    txn("wr7ffff", 1'b0, 2, 1'b1, 19'h7FFFF, 8'hC3, 1'b0, 1'b0, acc1);

    // Back-to-back with req held high: write then read of 0x10.
    txn("b2b_wr", 1'b0, 2, 1'b1, 19'h00010, 8'h3C, 1'b1, 1'b0, acc1);
    txn("b2b_rd", 1'b0, 2, 1'b0, 19'h00010, 8'h00, 1'b0, 1'b0, acc2);
    check("b2b.spacing", 32'(acc2 - acc1), 32'd5);

    // Request while busy: ignored, no second transaction follows.
    txn("busy_rd", 1'b0, 2, 1'b0, 19'h00010, 8'h00, 1'b0, 1'b1, acc1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("busy.idle_ce_n@%0d", i), 32'(obs.ce_n), 32'd1);
      check($sformatf("busy.idle_done@%0d", i), 32'(obs.done), 32'd0);
      check($sformatf("busy.idle_addr@%0d", i), 32'(obs.addr), 32'h00010);
    end

    // Randomized traffic against the reference memory.
    for (int i = 0; i < 12; i++) begin
      bit            r_wr;
      logic [AW-1:0] r_a;
      logic [DW-1:0] r_d;
      r_wr = (wr_q.size() == 0) || ($urandom_range(1, 0) == 1);
      r_d  = 8'($urandom);
      if (r_wr) begin
        r_a = 19'h00100 + 19'($urandom_range(15, 0));
        wr_q.push_back(r_a);
      end else begin
        r_a = wr_q[$urandom_range(wr_q.size() - 1, 0)];
      end
      txn($sformatf("rnd%0d", i), 1'b0, 2, r_wr, r_a, r_d, 1'b0, 1'b0, acc1);
    end

    // Minimum wait on the WAIT_CYC=1 controller.
    txn("w1_rd", 1'b1, 1, 1'b0, 19'h01234, 8'h00, 1'b0, 1'b0, acc1);
    txn("w1_wr", 1'b1, 1, 1'b1, 19'h00105, 8'hA7, 1'b0, 1'b0, acc1);
    txn("w1_rb", 1'b1, 1, 1'b0, 19'h00105, 8'h00, 1'b0, 1'b0, acc1);

    // Reset in the first ACCESS cycle of a write.
    sel = 1'b0;
    @(negedge clk);
    we = 1'b1; addr = 19'h00333; wdata = 8'h99; req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    check("abort.setup_ce_n", 32'(obs.ce_n), 32'd0);
    @(negedge clk);
    check("abort.access_we_n", 32'(obs.we_n), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort.ce_n",    32'(obs.ce_n),    32'd1);
    check("abort.we_n",    32'(obs.we_n),    32'd1);
    check("abort.oe_n",    32'(obs.oe_n),    32'd1);
    check("abort.sram_oe", 32'(obs.sram_oe), 32'd0);
    check("abort.done",    32'(obs.done),    32'd0);
    check("abort.ready",   32'(obs.ready),   32'd1);
    check("abort.rdata",   32'(obs.rdata),   32'd0);
    check("abort.addr",    32'(obs.addr),    32'd0);
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("abort.no_done@%0d", i), 32'(obs.done), 32'd0);
      check($sformatf("abort.idle@%0d", i),    32'(obs.ce_n), 32'd1);
    end

    // Controller is fully usable again after the abort.
    txn("post_abort_rd", 1'b0, 2, 1'b0, 19'h7FFFF, 8'h00, 1'b0, 1'b0, acc1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
